// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use and flag hazards,
// branch flush, memory-wait freeze with timeout halt, and a stall counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DELAY_SLOT  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic             id_uses_flags,
    input  logic             br_taken,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_flag_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             ex_mem_en,
    output logic             memwb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic   [WAIT_W-1:0] wait_cnt;
    logic   [WAIT_W-1:0] wait_nxt;

    logic lu;
    logic fu;
    logic mw;

    logic run_pc_en;
    logic run_ifid_en;
    logic run_ifid_flush;
    logic run_idex_bubble;
    logic run_ex_mem_en;
    logic run_memwb_bubble;

    // X31 is the zero register and never carries a dependency
    assign lu = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd31)
              & ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));
    assign fu = id_valid & id_uses_flags & ex_valid & ex_flag_en;
    assign mw = mem_req & ~mem_ready;

    // Outputs when no memory freeze is in effect
    always_comb begin
        run_pc_en        = 1'b1;
        run_ifid_en      = 1'b1;
        run_ifid_flush   = 1'b0;
        run_idex_bubble  = 1'b0;
        run_ex_mem_en    = 1'b1;
        run_memwb_bubble = 1'b0;
        if (lu || fu) begin
            run_pc_en       = 1'b0;
            run_ifid_en     = 1'b0;
            run_idex_bubble = 1'b1;
        end else if (br_taken) begin
            run_ifid_flush = (DELAY_SLOT == 0);
        end
    end

    // Next-state and output selection
    always_comb begin
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        pc_en        = run_pc_en;
        ifid_en      = run_ifid_en;
        ifid_flush   = run_ifid_flush;
        idex_bubble  = run_idex_bubble;
        ex_mem_en    = run_ex_mem_en;
        memwb_bubble = run_memwb_bubble;

        case (state)
            S_RUN: begin
                if (mw) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    ifid_flush   = 1'b0;
                    idex_bubble  = 1'b0;
                    ex_mem_en    = 1'b0;
                    memwb_bubble = 1'b1;
                    state_nxt    = S_MEM_WAIT;
                    wait_nxt     = WAIT_W'(1);
                end
            end
            S_MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt = S_RUN;
                    wait_nxt  = '0;
                end else begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    ifid_flush   = 1'b0;
                    idex_bubble  = 1'b0;
                    ex_mem_en    = 1'b0;
                    memwb_bubble = 1'b1;
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        state_nxt = S_HALT;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
            end
            S_HALT: begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                ifid_flush   = 1'b0;
                idex_bubble  = 1'b1;
                ex_mem_en    = 1'b0;
                memwb_bubble = 1'b1;
            end
            default: begin
                state_nxt = S_RUN;
                wait_nxt  = '0;
            end
        endcase

        // Reset overrides immediately, without waiting for a clock edge
        if (!reset) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            ex_mem_en    = 1'b0;
            memwb_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_RUN;
            wait_cnt    <= '0;
            halted      <= 1'b0;
            stall_count <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state_nxt == S_HALT) begin
                halted <= 1'b1;
            end
            if ((state != S_HALT) && !pc_en && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed test-plan steps followed
// by random traffic, compared against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TO    = 15;
    localparam int unsigned CNT_A = 16;
    localparam int unsigned CNT_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       id_valid, id_uses_rm, id_uses_flags, br_taken;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic       ex_valid, ex_mem_read, ex_flag_en, mem_req, mem_ready;

    logic             a_pc_en, a_ifid_en, a_ifid_flush, a_idex_bubble, a_ex_mem_en, a_memwb_bubble, a_halted;
    logic [CNT_A-1:0] a_stall_count;
    logic             b_pc_en, b_ifid_en, b_ifid_flush, b_idex_bubble, b_ex_mem_en, b_memwb_bubble, b_halted;
    logic [CNT_B-1:0] b_stall_count;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_A), .DELAY_SLOT(0)) u_dut_a (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .id_uses_flags(id_uses_flags), .br_taken(br_taken),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_flag_en(ex_flag_en),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush),
        .idex_bubble(a_idex_bubble), .ex_mem_en(a_ex_mem_en), .memwb_bubble(a_memwb_bubble),
        .halted(a_halted), .stall_count(a_stall_count)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_B), .DELAY_SLOT(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .id_uses_flags(id_uses_flags), .br_taken(br_taken),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_flag_en(ex_flag_en),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush),
        .idex_bubble(b_idex_bubble), .ex_mem_en(b_ex_mem_en), .memwb_bubble(b_memwb_bubble),
        .halted(b_halted), .stall_count(b_stall_count)
    );

    int checks   = 0;
    int failures = 0;

    // Model: consecutive memory-frozen cycles, sticky halt, stall totals
    int m_frozen = 0;
    bit m_halted = 1'b0;
    int m_cnt_a  = 0;
    int m_cnt_b  = 0;

    // {pc_en, ifid_en, ifid_flush, idex_bubble, ex_mem_en, memwb_bubble}
    function automatic logic [5:0] exp_outs(input bit delay_slot);
        bit lu, fu, frozen;
        lu = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd31)
             && ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
        fu = id_valid && id_uses_flags && ex_valid && ex_flag_en;
        frozen = !mem_ready && ((m_frozen > 0) || mem_req);
        if (!reset)        return 6'b001101;
        else if (m_halted) return 6'b000101;
        else if (frozen)   return 6'b000001;
        else if (lu || fu) return 6'b000110;
        else if (br_taken) return {2'b11, !delay_slot, 3'b010};
        else               return 6'b110010;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        check("outs_a", 32'({a_pc_en, a_ifid_en, a_ifid_flush, a_idex_bubble, a_ex_mem_en, a_memwb_bubble}),
              32'(exp_outs(1'b0)));
        check("outs_b", 32'({b_pc_en, b_ifid_en, b_ifid_flush, b_idex_bubble, b_ex_mem_en, b_memwb_bubble}),
              32'(exp_outs(1'b1)));
        check("halted_a", 32'(a_halted), 32'(reset && m_halted));
        check("halted_b", 32'(b_halted), 32'(reset && m_halted));
        check("cnt_a", 32'(a_stall_count), reset ? 32'(m_cnt_a) : 32'd0);
        check("cnt_b", 32'(b_stall_count), reset ? 32'(m_cnt_b) : 32'd0);
    endtask

    task automatic model_edge();
        logic [5:0] e;
        if (!reset) begin
            m_frozen = 0;
            m_halted = 1'b0;
            m_cnt_a  = 0;
            m_cnt_b  = 0;
        end else if (!m_halted) begin
            e = exp_outs(1'b0);
            if (!e[5]) begin
                if (m_cnt_a < (1 << CNT_A) - 1) m_cnt_a++;
                if (m_cnt_b < (1 << CNT_B) - 1) m_cnt_b++;
            end
            if (!mem_ready && ((m_frozen > 0) || mem_req)) begin
                m_frozen++;
                if (m_frozen == TO + 1) m_halted = 1'b1;
            end else begin
                m_frozen = 0;
            end
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs checked at the falling edge
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_id(input bit v, input logic [4:0] rn, input logic [4:0] rm,
                          input bit urm, input bit uf, input bit br);
        id_valid = v; id_rn = rn; id_rm = rm; id_uses_rm = urm; id_uses_flags = uf; br_taken = br;
    endtask

    task automatic set_ex(input bit v, input logic [4:0] rd, input bit mr, input bit fe);
        ex_valid = v; ex_rd = rd; ex_mem_read = mr; ex_flag_en = fe;
    endtask

    task automatic set_mem(input bit rq, input bit rdy);
        mem_req = rq; mem_ready = rdy;
    endtask

    function automatic logic [4:0] rnd_reg();
        int unsigned r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        reset = 1'b0;
        set_id(0, 0, 0, 0, 0, 0);
        set_ex(0, 0, 0, 0);
        set_mem(0, 0);
        #1;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();

        // Load-use: LDUR X2 in EX, ADD X3,X2,X4 in RF
        set_ex(1, 5'd2, 1, 0);
        set_id(1, 5'd2, 5'd4, 1, 0, 0);
        cycle();
        set_ex(0, 5'd2, 1, 0);
        cycle();

        // X31 never hazards; unused Rm never hazards
        set_ex(1, 5'd31, 1, 0);
        set_id(1, 5'd31, 5'd31, 1, 0, 0);
        cycle();
        set_ex(1, 5'd5, 1, 0);
        set_id(1, 5'd1, 5'd5, 0, 0, 0);
        cycle();

        // Flag hazard on B.cond with taken branch, then branch resolves
        set_ex(1, 5'd9, 0, 1);
        set_id(1, 5'd0, 5'd0, 0, 1, 1);
        cycle();
        set_ex(0, 5'd9, 0, 0);
        cycle();
        set_id(0, 0, 0, 0, 0, 0);
        cycle();

        // Memory wait of three cycles, released in the ready cycle
        set_mem(1, 0);
        repeat (3) cycle();
        set_mem(1, 1);
        cycle();
        set_mem(0, 0);
        cycle();

        // Timeout into sticky halt
        set_mem(1, 0);
        repeat (20) cycle();
        set_mem(0, 1);
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();

        // Asynchronous reset in the middle of a memory wait
        set_mem(1, 0);
        repeat (2) cycle();
        #3;
        reset = 1'b0;
        #1;
        check_all();
        cycle();
        reset = 1'b1;
        set_mem(0, 0);
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            set_id($urandom_range(0, 3) != 0, rnd_reg(), rnd_reg(), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            set_ex($urandom_range(0, 3) != 0, rnd_reg(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            set_mem($urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 79) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline (IF, RF, EX, MEM, WB).
- Inspects RF-stage source registers, EX-stage destination/flags and MEM-stage memory handshake.
- Drives per-stage enables, bubble inserts and the IF/RF flush.
- Tracks multi-cycle memory waits with a timeout, and keeps a saturating stall counter for performance debug.

Parameters:
MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before fatal halt (1..255)
CNT_W, 16, width of stall_count
DELAY_SLOT, 1, 1 = instruction after a taken branch executes (no flush); 0 = flush IF/RF on taken branch

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low; 0 = reset
id_valid  in  1  RF stage holds a real instruction
id_rn  in  5  RF source register Rn
id_rm  in  5  RF second source (Rm or Rd per Reg2Loc)
id_uses_rm  in  1  second source is actually read
id_uses_flags  in  1  RF instruction is B.cond (reads flags)
br_taken  in  1  branch resolved taken in RF this cycle
ex_valid  in  1  EX stage holds a real instruction
ex_rd  in  5  EX destination register
ex_mem_read  in  1  EX instruction is a load
ex_flag_en  in  1  EX instruction sets flags
mem_req  in  1  MEM stage is performing a data-memory access
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC update enable
ifid_en  out  1  IF/RF register load enable
ifid_flush  out  1  IF/RF register loads a NOP
idex_bubble  out  1  RF/EX register loads a NOP (control bits zero)
ex_mem_en  out  1  EX/MEM register load enable
memwb_bubble  out  1  MEM/WB register loads a NOP
halted  out  1  sticky fatal-timeout flag
stall_count  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- States: RUN, MEM_WAIT, HALT. State and counters are registered. All outputs are combinational from state and inputs (same-cycle effect).

Reset:
- While reset=0: state=RUN, wait_cnt=0, stall_count=0, halted=0.
- Outputs forced to pc_en=0, ifid_en=0, ex_mem_en=0, ifid_flush=1, idex_bubble=1, memwb_bubble=1.

Hazard terms:
- Load-use (lu) = id_valid & ex_valid & ex_mem_read & ex_rd!=31 & (ex_rd==id_rn | (id_uses_rm & ex_rd==id_rm)). X31 never creates a hazard.
- Flag-use (fu) = id_valid & id_uses_flags & ex_valid & ex_flag_en.
- mw = mem_req & ~mem_ready.

RUN, priority mw > (lu|fu) > br_taken > none:
- mw: freeze everything this cycle: pc_en=0, ifid_en=0, idex_bubble=0, ex_mem_en=0, memwb_bubble=1. Next state MEM_WAIT, wait_cnt=1.
- lu|fu (no mw): pc_en=0, ifid_en=0, idex_bubble=1, ex_mem_en=1, memwb_bubble=0. Stays RUN; the stall clears naturally the next cycle. br_taken is ignored this cycle; the branch is re-evaluated next cycle.
- br_taken only: all enables 1, no bubbles. ifid_flush = ~DELAY_SLOT.
- none: pc_en=ifid_en=ex_mem_en=1, all bubbles/flush 0.

MEM_WAIT:
- Same freeze outputs as mw; br_taken, lu and fu are ignored.
- mem_ready=1: release freeze in the same cycle (RUN rules apply combinationally to current inputs) and go to RUN; wait_cnt=0.
- mem_ready=0 and wait_cnt==MEM_TIMEOUT: go to HALT, set halted=1.
- Otherwise wait_cnt++.

HALT:
- pc_en=ifid_en=ex_mem_en=0, idex_bubble=memwb_bubble=1.
- Exit only via reset.

stall_count:
- Increments each cycle pc_en=0 while reset=1 and state!=HALT.
- Saturates at all-ones, no wrap.

Reset mid-operation:
- Reset asserted in MEM_WAIT or HALT returns immediately to the reset values; no pending wait is remembered.

Test Plan:
- Load-use: EX LDUR X2 (ex_mem_read=1, ex_rd=2), RF ADD X3,X2,X4 (id_rn=2) -> one cycle pc_en=0, ifid_en=0, idex_bubble=1; next cycle (ex_valid=0) all enables 1; stall_count=1.
- X31 / unused Rm: ex_rd=31 with id_rn=31, or ex_rd=id_rm with id_uses_rm=0 -> no stall, pc_en=1.
- Flag hazard with branch: EX SUBS (ex_flag_en=1), RF B.cond with id_uses_flags=1 and br_taken=1 -> stall 1 cycle with ifid_flush=0. Next cycle br_taken=1 with DELAY_SLOT=0 -> ifid_flush=1 for exactly one cycle.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 freeze cycles with memwb_bubble=1 and ex_mem_en=0; release in the ready cycle; stall_count=3.
- Timeout: mem_ready held 0 with MEM_TIMEOUT=15 -> HALT entered after the 16th wait cycle. halted=1 stays sticky, stall_count stops incrementing. reset=0 pulse clears halted=0, stall_count=0, state=RUN.
- Async reset: assert reset=0 mid-cycle during MEM_WAIT -> outputs take reset values immediately, without waiting for a clock edge.
